// File: rtl/hex_keypad_entry_if.sv
// Keypad-side and number-side signals of the hex keypad entry block.
// The slave modport is the block itself; master is whatever drives the keypad and reads N.
interface hex_keypad_entry_if;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic        Clr;
    logic [31:0] N;
    logic        KeyValid;
    logic [3:0]  KeyCode;

    modport master (
        output ROW,
        output Clr,
        input  COL,
        input  N,
        input  KeyValid,
        input  KeyCode
    );

    modport slave (
        input  ROW,
        input  Clr,
        output COL,
        output N,
        output KeyValid,
        output KeyCode
    );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce; shifts each accepted digit into a 32-bit word.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SCAN     | rotate the low column once per dwell, looking for a low row
// DEBOUNCE | column frozen, counting consecutive samples of the same row
// ACCEPT   | one cycle: KeyValid high, KeyCode/N already hold the new digit
// HELD     | column frozen, waiting for consecutive all-high samples
module hex_keypad_entry #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input logic              Clk,
    input logic              Rst_n,
    hex_keypad_entry_if.slave kp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_N + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        HELD     = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [3:0]      row_meta;
    logic [3:0]      rs;
    logic [DW-1:0]   dwell;
    logic            sample;
    logic [1:0]      col_idx;
    logic [1:0]      col_d;
    logic [MW-1:0]   match_cnt;
    logic [MW-1:0]   match_d;
    logic [MW-1:0]   match_inc;
    logic            match_done;
    logic [3:0]      cand;
    logic [3:0]      cand_d;
    logic [1:0]      row_enc;
    logic            any_low;
    logic            accept_d;
    logic [31:0]     n_q;
    logic [3:0]      key_code_q;

    // ROW is asynchronous to Clk; nothing downstream looks at it unsynchronized.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= kp.ROW;
            rs       <= row_meta;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign sample     = (dwell == DW'(SCAN_DIV - 1));
    assign any_low    = ~(&rs);
    assign match_inc  = match_cnt + MW'(1);
    assign match_done = (match_inc == MW'(DEBOUNCE_N));

    always_comb begin
        row_enc = 2'd3;
        if (!rs[0]) begin
            row_enc = 2'd0;
        end else if (!rs[1]) begin
            row_enc = 2'd1;
        end else if (!rs[2]) begin
            row_enc = 2'd2;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            match_cnt <= '0;
            cand      <= 4'd0;
        end else begin
            state     <= state_d;
            col_idx   <= col_d;
            match_cnt <= match_d;
            cand      <= cand_d;
        end
    end

    always_comb begin
        state_d = state;
        col_d   = col_idx;
        match_d = match_cnt;
        cand_d  = cand;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (!any_low) begin
                        col_d = col_idx + 2'd1;
                    end else begin
                        cand_d  = {row_enc, col_idx};
                        match_d = MW'(1);
                        state_d = (DEBOUNCE_N == 1) ? ACCEPT : DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (any_low && (row_enc == cand[3:2])) begin
                        match_d = match_inc;
                        if (match_done) begin
                            state_d = ACCEPT;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_idx + 2'd1;
                    end
                end
            end
            ACCEPT: begin
                state_d = HELD;
                match_d = '0;
            end
            HELD: begin
                // Any low sample restarts the release count, so a bouncing release
                // never produces a second press.
                if (sample) begin
                    if (any_low) begin
                        match_d = '0;
                    end else if (match_done) begin
                        match_d = '0;
                        state_d = SCAN;
                        col_d   = col_idx + 2'd1;
                    end else begin
                        match_d = match_inc;
                    end
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Digit registers load on the edge into ACCEPT so they are valid alongside KeyValid.
    assign accept_d = (state_d == ACCEPT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            n_q        <= 32'd0;
            key_code_q <= 4'd0;
        end else begin
            if (accept_d) begin
                key_code_q <= cand_d;
            end
            if (kp.Clr) begin
                n_q <= 32'd0;
            end else if (accept_d) begin
                n_q <= {n_q[27:0], cand_d};
            end
        end
    end

    always_comb begin
        kp.KeyValid = (state == ACCEPT);
        kp.COL      = ~(4'b0001 << col_idx);
        kp.N        = n_q;
        kp.KeyCode  = key_code_q;
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad matrix model.
module tb_hex_keypad_entry;

    logic       Clk;
    logic       Rst_n;
    logic       key_down;
    logic [3:0] key_num;
    logic       glitch;
    int         vectors;
    int         errors;
    int         kv_cnt;
    logic [3:0] kv_code;
    logic [31:0] kv_n;

    hex_keypad_entry_if kp();

    hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .kp    (kp.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pressed key shorts its row to its column; glitch models contact bounce open.
    always_comb begin
        kp.ROW = 4'b1111;
        if (key_down && !glitch && (kp.COL[key_num[1:0]] == 1'b0)) begin
            kp.ROW[key_num[3:2]] = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (kp.KeyValid === 1'b1) begin
            kv_cnt  = kv_cnt + 1;
            kv_code = kp.KeyCode;
            kv_n    = kp.N;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] c, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (kp.COL === c) seen = 1'b1;
            else step(1);
        end
        if (kp.COL === c) seen = 1'b1;
    endtask

    task automatic press(input logic [3:0] k, input int hold, output bit resumed);
        logic [3:0] frozen;
        frozen   = ~(4'b0001 << k[1:0]);
        key_num  = k;
        key_down = 1'b1;
        step(hold);
        key_down = 1'b0;
        resumed  = 1'b0;
        for (int i = 0; i < 40 && !resumed; i++) begin
            step(1);
            if (kp.COL !== frozen) resumed = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        step(7);
        #2 Rst_n = 1'b0;
        #1;
        vectors++; if (kp.COL !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", kp.COL); end
        vectors++; if (kp.N !== 32'd0) begin errors++; $display("FAIL reset_n: got %h want 0", kp.N); end
        vectors++; if (kp.KeyValid !== 1'b0) begin errors++; $display("FAIL reset_kv: got %b want 0", kp.KeyValid); end
        vectors++; if (kp.KeyCode !== 4'd0) begin errors++; $display("FAIL reset_code: got %h want 0", kp.KeyCode); end
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        vectors++; if (kp.COL !== 4'b1110) begin errors++; $display("FAIL rot_col0: got %b want 1110", kp.COL); end
        for (int i = 1; i <= 16; i++) begin
            step(1);
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            vectors++; if (kp.COL !== exp_col) begin errors++; $display("FAIL rot_col cycle %0d: got %b want %b", i, kp.COL, exp_col); end
        end
    endtask

    task automatic test_clean_press;
        int  kv0;
        bit  seen;
        kv0      = kv_cnt;
        key_num  = 4'd6;
        key_down = 1'b1;
        wait_col(4'b1011, 20, seen);
        vectors++; if (!seen) begin errors++; $display("FAIL k6_reach_col: got %b want 1011", kp.COL); end
        step(6);
        vectors++; if (kp.COL !== 4'b1011) begin errors++; $display("FAIL k6_frozen: got %b want 1011", kp.COL); end
        step(20);
        vectors++; if (kv_cnt - kv0 !== 1) begin errors++; $display("FAIL k6_pulses: got %0d want 1", kv_cnt - kv0); end
        vectors++; if (kv_code !== 4'h6) begin errors++; $display("FAIL k6_code: got %h want 6", kv_code); end
        vectors++; if (kv_n !== 32'h00000006) begin errors++; $display("FAIL k6_n: got %h want 00000006", kv_n); end
        vectors++; if (kp.N !== 32'h00000006) begin errors++; $display("FAIL k6_n_held: got %h want 00000006", kp.N); end
        key_down = 1'b0;
        step(9);
        vectors++; if (kp.COL !== 4'b1011) begin errors++; $display("FAIL k6_release_early: got %b want 1011", kp.COL); end
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step(1);
            if (kp.COL !== 4'b1011) seen = 1'b1;
        end
        vectors++; if (kp.COL !== 4'b0111) begin errors++; $display("FAIL k6_resume: got %b want 0111", kp.COL); end
    endtask

    task automatic test_nine_digits;
        int kv0;
        bit ok;
        kv0 = kv_cnt;
        for (int k = 1; k <= 9; k++) begin
            press(4'(k), 40, ok);
            vectors++; if (!ok) begin errors++; $display("FAIL nine_resume key %0d: got stuck want resume", k); end
        end
        vectors++; if (kv_cnt - kv0 !== 9) begin errors++; $display("FAIL nine_pulses: got %0d want 9", kv_cnt - kv0); end
        vectors++; if (kp.N !== 32'h23456789) begin errors++; $display("FAIL nine_n: got %h want 23456789", kp.N); end
    endtask

    task automatic test_bounce;
        int          kv0;
        logic [31:0] n0;
        bit          seen;
        kv0 = kv_cnt;
        n0  = kp.N;
        wait_col(4'b1101, 20, seen);
        key_num  = 4'd0;
        key_down = 1'b1;
        wait_col(4'b1110, 20, seen);
        vectors++; if (!seen) begin errors++; $display("FAIL bounce_reach_col: got %b want 1110", kp.COL); end
        step(4);
        key_down = 1'b0;
        vectors++; if (kp.COL !== 4'b1110) begin errors++; $display("FAIL bounce_frozen: got %b want 1110", kp.COL); end
        step(4);
        vectors++; if (kp.COL !== 4'b1101) begin errors++; $display("FAIL bounce_resume: got %b want 1101", kp.COL); end
        step(8);
        vectors++; if (kv_cnt - kv0 !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", kv_cnt - kv0); end
        vectors++; if (kp.N !== n0) begin errors++; $display("FAIL bounce_n: got %h want %h", kp.N, n0); end
    endtask

    task automatic test_hold_glitch;
        int kv0;
        bit got;
        bit ok;
        kv0      = kv_cnt;
        key_num  = 4'hF;
        key_down = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1);
            if (kv_cnt != kv0) got = 1'b1;
        end
        vectors++; if (!got) begin errors++; $display("FAIL kf_accept: got no pulse want 1"); end
        step(20);
        glitch = 1'b1; step(4);
        glitch = 1'b0; step(4);
        glitch = 1'b1; step(8);
        glitch = 1'b0; step(4);
        glitch = 1'b1; step(8);
        glitch = 1'b0; step(140);
        vectors++; if (kp.COL !== 4'b0111) begin errors++; $display("FAIL kf_frozen: got %b want 0111", kp.COL); end
        vectors++; if (kv_cnt - kv0 !== 1) begin errors++; $display("FAIL kf_pulses: got %0d want 1", kv_cnt - kv0); end
        vectors++; if (kv_code !== 4'hF) begin errors++; $display("FAIL kf_code: got %h want f", kv_code); end
        vectors++; if (kp.KeyCode !== 4'hF) begin errors++; $display("FAIL kf_code_held: got %h want f", kp.KeyCode); end
        key_down = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1);
            if (kp.COL !== 4'b0111) ok = 1'b1;
        end
        vectors++; if (kp.COL !== 4'b1110) begin errors++; $display("FAIL kf_resume: got %b want 1110", kp.COL); end
    endtask

    task automatic test_clr;
        int kv0;
        bit ok;
        bit hit;
        kp.Clr = 1'b1;
        step(1);
        kp.Clr = 1'b0;
        vectors++; if (kp.N !== 32'd0) begin errors++; $display("FAIL clr_n: got %h want 0", kp.N); end
        vectors++; if (kp.KeyCode !== 4'hF) begin errors++; $display("FAIL clr_code_kept: got %h want f", kp.KeyCode); end
        for (int k = 1; k <= 8; k++) press(4'(k), 40, ok);
        vectors++; if (kp.N !== 32'h12345678) begin errors++; $display("FAIL clr_preload: got %h want 12345678", kp.N); end
        kv0      = kv_cnt;
        key_num  = 4'hA;
        key_down = 1'b1;
        hit      = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(1);
            if (kp.KeyValid === 1'b1) hit = 1'b1;
        end
        vectors++; if (!hit) begin errors++; $display("FAIL clr_accept_seen: got no pulse want 1"); end
        kp.Clr = 1'b1;
        step(1);
        kp.Clr = 1'b0;
        vectors++; if (kp.N !== 32'd0) begin errors++; $display("FAIL clr_accept_n: got %h want 0", kp.N); end
        vectors++; if (kp.KeyCode !== 4'hA) begin errors++; $display("FAIL clr_accept_code: got %h want a", kp.KeyCode); end
        vectors++; if (kv_cnt - kv0 !== 1) begin errors++; $display("FAIL clr_accept_pulses: got %0d want 1", kv_cnt - kv0); end
        step(30);
        key_down = 1'b0;
        step(20);
    endtask

    task automatic test_reset_in_debounce;
        int kv0;
        bit ok;
        press(4'd7, 40, ok);
        vectors++; if (kp.N !== 32'h00000007) begin errors++; $display("FAIL rd_preload: got %h want 00000007", kp.N); end
        wait_col(4'b1110, 20, ok);
        key_num  = 4'd5;
        key_down = 1'b1;
        wait_col(4'b1101, 20, ok);
        step(6);
        vectors++; if (kp.COL !== 4'b1101) begin errors++; $display("FAIL rd_frozen: got %b want 1101", kp.COL); end
        #2 Rst_n = 1'b0;
        key_down = 1'b0;
        #1;
        vectors++; if (kp.COL !== 4'b1110) begin errors++; $display("FAIL rd_col: got %b want 1110", kp.COL); end
        vectors++; if (kp.N !== 32'd0) begin errors++; $display("FAIL rd_n: got %h want 0", kp.N); end
        vectors++; if (kp.KeyCode !== 4'd0) begin errors++; $display("FAIL rd_code: got %h want 0", kp.KeyCode); end
        step(2);
        Rst_n = 1'b1;
        kv0 = kv_cnt;
        step(40);
        vectors++; if (kv_cnt - kv0 !== 0) begin errors++; $display("FAIL rd_pulses: got %0d want 0", kv_cnt - kv0); end
        vectors++; if (kp.N !== 32'd0) begin errors++; $display("FAIL rd_n_after: got %h want 0", kp.N); end
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        kv_cnt   = 0;
        kv_code  = 4'd0;
        kv_n     = 32'd0;
        Rst_n    = 1'b0;
        kp.Clr   = 1'b0;
        key_down = 1'b0;
        key_num  = 4'd0;
        glitch   = 1'b0;
        step(3);
        Rst_n = 1'b1;
        test_reset;
        test_clean_press;
        test_nine_digits;
        test_bounce;
        test_hold_glitch;
        test_clr;
        test_reset_in_debounce;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
